// File: rtl/mips_debug_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_ctrl_if
// Description : UART command/response and pipeline control bundle between
//               the debug controller (master) and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_debug_ctrl_if #(
    parameter int NB_BITS = 32,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               i_tx_busy;
    logic [NB_BITS-1:0] i_pc;
    logic [NB_BITS-1:0] i_wb_data;
    logic               i_halt;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_mips_en;
    logic               o_mips_rst;
    logic               o_running;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_pc, i_wb_data, i_halt,
        output o_tx_data, o_tx_start, o_mips_en, o_mips_rst, o_running
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_busy, i_pc, i_wb_data, i_halt,
        input  o_tx_data, o_tx_start, o_mips_en, o_mips_rst, o_running
    );
endinterface
`default_nettype wire

// File: rtl/mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_ctrl
// Description : UART-driven run/step/reset/halt controller for the MIPS
//               pipeline; dumps {PC, WB data, cycle count} as 12 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_ctrl #(
    parameter int NB_BITS = 32,
    parameter int NB_BYTE = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mips_debug_ctrl_if.master bus
);

    localparam int c_NUM_BYTES = (3 * NB_BITS) / NB_BYTE;
    localparam int c_IDX_W     = $clog2(c_NUM_BYTES);

    localparam logic [NB_BYTE-1:0] c_CMD_RUN  = NB_BYTE'(8'h63);
    localparam logic [NB_BYTE-1:0] c_CMD_STEP = NB_BYTE'(8'h73);
    localparam logic [NB_BYTE-1:0] c_CMD_DUMP = NB_BYTE'(8'h64);
    localparam logic [NB_BYTE-1:0] c_CMD_RSTP = NB_BYTE'(8'h72);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_RSTP = 3'd3,
        ST_LOAD = 3'd4,
        ST_SEND = 3'd5,
        ST_WAIT = 3'd6
    } state_t;

    state_t                                   state_q, state_d;
    logic [NB_BITS-1:0]                       cnt_q, cnt_d;
    logic [0:c_NUM_BYTES-1][NB_BYTE-1:0]      snap_q, snap_d;
    logic [c_IDX_W-1:0]                       idx_q, idx_d;
    logic                                     wait_first_q, wait_first_d;
    logic [NB_BYTE-1:0]                       tx_data_q, tx_data_d;
    logic                                     tx_start_q, tx_start_d;
    logic                                     mips_en_q, mips_en_d;
    logic                                     mips_rst_q, mips_rst_d;
    logic                                     running_q, running_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        wait_first_d = 1'b0;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;

        // Count every cycle the pipeline actually advanced, sticking at all-ones.
        if (mips_en_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + NB_BITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        c_CMD_RUN:  state_d = ST_RUN;
                        c_CMD_STEP: state_d = ST_STEP;
                        c_CMD_DUMP: state_d = ST_LOAD;
                        c_CMD_RSTP: state_d = ST_RSTP;
                        default:    state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.i_halt) begin
                    state_d = ST_LOAD;
                end
            end
            ST_STEP: begin
                state_d = ST_LOAD;
            end
            ST_RSTP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                snap_d  = {bus.i_pc, bus.i_wb_data, cnt_q};
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!bus.i_tx_busy) begin
                    tx_data_d    = snap_q[idx_q];
                    tx_start_d   = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Busy only rises the cycle after the start pulse, so the
                // first WAIT cycle cannot trust it.
                if (!wait_first_q && !bus.i_tx_busy) begin
                    idx_d   = idx_q + c_IDX_W'(1);
                    state_d = (idx_q == c_LAST_IDX) ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mips_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
        mips_rst_d = (state_d == ST_RSTP);
        running_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            wait_first_q <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            mips_en_q    <= 1'b0;
            mips_rst_q   <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            wait_first_q <= wait_first_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            mips_en_q    <= mips_en_d;
            mips_rst_q   <= mips_rst_d;
            running_q    <= running_d;
        end
    end

    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_mips_en  = mips_en_q;
    assign bus.o_mips_rst = mips_rst_q;
    assign bus.o_running  = running_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_debug_ctrl
// Description : Scoreboard bench for mips_debug_ctrl with a UART transmitter
//               model and a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_debug_ctrl;

    localparam int NB_BITS = 32;
    localparam int NB_BYTE = 8;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int en_cnt, rst_cnt, run_cnt, start_cnt;
    int en_last_cyc, first_start_cyc, last_start_cyc;
    int busy_len  = 1;
    bit gap_check = 1'b1;

    logic [7:0]  exp_q[$];
    logic [31:0] m_cycles;

    mips_debug_ctrl_if #(.NB_BITS(NB_BITS), .NB_BYTE(NB_BYTE)) dbg_if ();

    mips_debug_ctrl #(.NB_BITS(NB_BITS), .NB_BYTE(NB_BYTE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dbg_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int k);
        longint s;
        s = longint'(a) + longint'(k);
        if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    // Expected dump: PC, WB, cycles, each MSB first.
    task automatic push_dump();
        logic [95:0] snap;
        snap = {dbg_if.i_pc, dbg_if.i_wb_data, m_cycles};
        for (int i = 0; i < 12; i++) exp_q.push_back(snap[95 - 8*i -: 8]);
    endtask

    // Transmitter: busy from the cycle after a start, for busy_len cycles.
    initial begin
        dbg_if.i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (dbg_if.o_tx_start === 1'b1) begin
                @(posedge clk);
                #1 dbg_if.i_tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 dbg_if.i_tx_busy = 1'b0;
            end
        end
    end

    // Monitor: activity counters and byte scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (dbg_if.o_mips_en === 1'b1) begin
                en_cnt++;
                en_last_cyc = cyc;
            end
            if (dbg_if.o_running === 1'b1) run_cnt++;
            if (dbg_if.o_mips_rst === 1'b1) rst_cnt++;
            if (dbg_if.o_tx_start === 1'b1) begin
                check("start_while_busy", dbg_if.i_tx_busy, 0);
                if (start_cnt == 0) first_start_cyc = cyc;
                else if (gap_check) check("start_gap", cyc - last_start_cyc, 4);
                last_start_cyc = cyc;
                start_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)",
                             dbg_if.o_tx_data, cyc);
                end else begin
                    check("tx_byte", dbg_if.o_tx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        dbg_if.i_rx_data  = b;
        dbg_if.i_rx_valid = 1'b1;
        @(negedge clk);
        dbg_if.i_rx_valid = 1'b0;
        dbg_if.i_rx_data  = 8'($urandom);
    endtask

    // Waits for the dump to drain; pipeline inputs wander once sending starts.
    task automatic wait_dump();
        int n;
        int budget;
        n = 0;
        budget = 12 * (busy_len + 8) + 100;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (start_cnt > 0) begin
                dbg_if.i_pc      = $urandom;
                dbg_if.i_wb_data = $urandom;
            end
        end
        repeat (2) @(negedge clk);
        while (dbg_if.i_tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_counts();
        en_cnt = 0; rst_cnt = 0; run_cnt = 0; start_cnt = 0;
        first_start_cyc = 0; en_last_cyc = 0;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input int k, input bit halt_pre,
                           input logic [31:0] pc, input logic [31:0] wb);
        int exp_en, exp_rst, exp_starts, exp_run, kk;
        exp_en = 0; exp_rst = 0; exp_starts = 0; exp_run = 0; kk = k;
        clear_counts();
        dbg_if.i_pc      = pc;
        dbg_if.i_wb_data = wb;
        case (cmd)
            8'h73: begin
                m_cycles = sat_add(m_cycles, 1);
                push_dump();
                exp_en = 1; exp_starts = 12;
                send_cmd(cmd);
                wait_dump();
                check("step_to_start", first_start_cyc - en_last_cyc, 3);
            end
            8'h63: begin
                if (halt_pre) begin
                    kk = 1;
                    dbg_if.i_halt = 1'b1;
                end
                m_cycles = sat_add(m_cycles, kk);
                push_dump();
                exp_en = kk; exp_run = kk; exp_starts = 12;
                send_cmd(cmd);
                for (int i = 1; i < kk; i++) begin
                    @(negedge clk);
                    dbg_if.i_rx_valid = (i == 1);
                    dbg_if.i_rx_data  = 8'h72;
                end
                dbg_if.i_rx_valid = 1'b0;
                dbg_if.i_halt     = 1'b1;
                @(negedge clk);
                dbg_if.i_halt = 1'b0;
                wait_dump();
                check("halt_to_start_ge2", longint'((first_start_cyc - en_last_cyc) >= 2), 1);
            end
            8'h64: begin
                push_dump();
                exp_starts = 12;
                send_cmd(cmd);
                wait_dump();
            end
            8'h72: begin
                m_cycles = 0;
                exp_rst = 1;
                send_cmd(cmd);
                repeat (4) @(negedge clk);
            end
            default: begin
                send_cmd(cmd);
                repeat (4) @(negedge clk);
            end
        endcase
        check("en_cycles", en_cnt, exp_en);
        check("rst_pulses", rst_cnt, exp_rst);
        check("tx_starts", start_cnt, exp_starts);
        check("run_cycles", run_cnt, exp_run);
        check("idle_outputs", {dbg_if.o_running, dbg_if.o_mips_en, dbg_if.o_mips_rst}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_cycles = 0;
    endtask

    initial begin
        int n, s0, r;
        logic [7:0] b;
        rst               = 1'b1;
        dbg_if.i_rx_data  = '0;
        dbg_if.i_rx_valid = 1'b0;
        dbg_if.i_pc       = '0;
        dbg_if.i_wb_data  = '0;
        dbg_if.i_halt     = 1'b0;
        m_cycles          = 0;
        clear_counts();

        repeat (3) @(negedge clk);
        check("reset_outputs", {dbg_if.o_tx_data, dbg_if.o_tx_start, dbg_if.o_mips_en,
                                dbg_if.o_mips_rst, dbg_if.o_running}, 0);
        rst = 1'b0;

        // Single step from reset.
        run_cmd(8'h73, 0, 1'b0, 32'h0000_0004, 32'h0000_ABCD);

        // Continuous run halted after 10 enable cycles.
        do_reset();
        run_cmd(8'h63, 10, 1'b0, $urandom, $urandom);

        // s, s, r, d.
        run_cmd(8'h73, 0, 1'b0, $urandom, $urandom);
        run_cmd(8'h73, 0, 1'b0, $urandom, $urandom);
        run_cmd(8'h72, 0, 1'b0, $urandom, $urandom);
        run_cmd(8'h64, 0, 1'b0, $urandom, $urandom);

        // Commands during a dump are dropped.
        clear_counts();
        dbg_if.i_pc = $urandom;
        dbg_if.i_wb_data = $urandom;
        push_dump();
        send_cmd(8'h64);
        repeat (6) @(negedge clk);
        send_cmd(8'h63);
        repeat (5) @(negedge clk);
        send_cmd(8'h73);
        wait_dump();
        check("drop_en_cycles", en_cnt, 0);
        check("drop_tx_starts", start_cnt, 12);

        // Slow transmitter.
        busy_len = 50;
        gap_check = 1'b0;
        run_cmd(8'h64, 0, 1'b0, $urandom, $urandom);
        busy_len = 1;
        gap_check = 1'b1;

        // Reset mid-dump after byte 5.
        clear_counts();
        dbg_if.i_pc = $urandom;
        dbg_if.i_wb_data = $urandom;
        push_dump();
        send_cmd(8'h64);
        n = 0;
        while (start_cnt < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte5", start_cnt, 5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {dbg_if.o_tx_data, dbg_if.o_tx_start, dbg_if.o_mips_en,
                                dbg_if.o_mips_rst, dbg_if.o_running}, 0);
        exp_q.delete();
        s0 = start_cnt;
        @(negedge clk);
        rst = 1'b0;
        m_cycles = 0;
        repeat (40) @(negedge clk);
        check("abort_no_more_tx", start_cnt, s0);
        run_cmd(8'h64, 0, 1'b0, $urandom, $urandom);

        // Randomized command stream.
        for (int t = 0; t < 40; t++) begin
            busy_len  = $urandom_range(1, 3);
            gap_check = (busy_len == 1);
            r = $urandom_range(0, 9);
            if (r <= 2)      run_cmd(8'h73, 0, 1'b0, $urandom, $urandom);
            else if (r <= 5) run_cmd(8'h63, $urandom_range(1, 8), 1'b0, $urandom, $urandom);
            else if (r == 6) run_cmd(8'h64, 0, 1'b0, $urandom, $urandom);
            else if (r == 7) run_cmd(8'h72, 0, 1'b0, $urandom, $urandom);
            else if (r == 8) begin
                b = 8'($urandom);
                while (b == 8'h63 || b == 8'h73 || b == 8'h64 || b == 8'h72) b = 8'($urandom);
                run_cmd(b, 0, 1'b0, $urandom, $urandom);
            end else begin
                run_cmd(8'h63, 0, 1'b1, $urandom, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
